// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes,
// FSM state encodings and source-select indices.
package wb_stage_pkg;

    // Load size/sign encodings carried in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Writeback FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_LD = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    // Conventional source slots of the packed source bus
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_PC4 = 2;
    localparam int SRC_IMM = 3;

    // Select width that never collapses to zero bits
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Combinational load formatter: picks the addressed byte/half/word lane
// out of the raw memory word and sign- or zero-extends it to XLEN.
module load_formatter
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int AW  = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      funct3_i,
    input  logic [AW-1:0]   addr_lo_i,
    output logic [XLEN-1:0] result_o
);

    // Halfword and word lanes ignore the sub-lane address bits, so
    // misaligned accesses simply land on the containing lane.
    logic [AW-1:0] hw_lane;
    logic [AW-1:0] wd_lane;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [31:0]   word_val;

    assign hw_lane  = addr_lo_i & ~AW'(1);
    assign wd_lane  = addr_lo_i & ~AW'(3);
    assign byte_val = raw_i[{addr_lo_i, 3'b000} +: 8];
    assign half_val = raw_i[{hw_lane, 3'b000} +: 16];
    assign word_val = raw_i[{wd_lane, 3'b000} +: 32];

    // Extend the selected lane according to funct3; unknown codes pass raw
    always_comb begin
        result_o = raw_i;
        case (funct3_i)
            F3_LB:   result_o = XLEN'(signed'(byte_val));
            F3_LBU:  result_o = XLEN'(byte_val);
            F3_LH:   result_o = XLEN'(signed'(half_val));
            F3_LHU:  result_o = XLEN'(half_val);
            F3_LW:   result_o = XLEN'(signed'(word_val));
            F3_LWU:  result_o = XLEN'(word_val);
            default: result_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: selects the write value from NUM_SRC sources,
// waits for and formats load data, and drives the register-file write port.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int MEM_SRC = SRC_MEM,
    parameter int RA_W    = 5,
    localparam int SEL_W  = sel_width(NUM_SRC),
    localparam int AW     = $clog2(XLEN / 8)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_SRC*XLEN-1:0] in_src,
    input  logic [RA_W-1:0]         in_rd,
    input  logic                    in_we,
    input  logic [2:0]              in_funct3,
    input  logic [AW-1:0]           in_addr_lo,
    input  logic                    mem_rvalid,
    input  logic [XLEN-1:0]         mem_rdata,
    input  logic                    flush,
    output logic                    rf_we,
    output logic [RA_W-1:0]         rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    busy
);

    logic [1:0]      state_q,    state_d;
    logic [RA_W-1:0] ld_rd_q,    ld_rd_d;
    logic            ld_we_q,    ld_we_d;
    logic [2:0]      ld_f3_q,    ld_f3_d;
    logic [AW-1:0]   ld_lo_q,    ld_lo_d;
    logic            rf_we_q,    rf_we_d;
    logic [RA_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic [XLEN-1:0] src_arr [NUM_SRC];
    logic [XLEN-1:0] sel_val;
    logic [XLEN-1:0] ld_fmt;

    // Unpack the source bus into one word per slot
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_arr[gi] = in_src[gi*XLEN +: XLEN];
    end

    // Out-of-range selects write zero
    always_comb begin
        sel_val = '0;
        if ({1'b0, in_sel} < (SEL_W+1)'(NUM_SRC)) begin
            sel_val = src_arr[in_sel];
        end
    end

    load_formatter #(.XLEN(XLEN)) u_fmt (
        .raw_i     (mem_rdata),
        .funct3_i  (ld_f3_q),
        .addr_lo_i (ld_lo_q),
        .result_o  (ld_fmt)
    );

    // Next-state and write-port logic; rf_we is a fresh single-cycle pulse
    always_comb begin
        state_d    = state_q;
        ld_rd_d    = ld_rd_q;
        ld_we_d    = ld_we_q;
        ld_f3_d    = ld_f3_q;
        ld_lo_d    = ld_lo_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (state_q)
            ST_IDLE: begin
                // A flushed offer is consumed with no effect
                if (in_valid && !flush) begin
                    if (in_sel == SEL_W'(MEM_SRC)) begin
                        ld_rd_d = in_rd;
                        ld_we_d = in_we;
                        ld_f3_d = in_funct3;
                        ld_lo_d = in_addr_lo;
                        state_d = ST_WAIT_LD;
                    end else begin
                        rf_we_d    = in_we && (in_rd != '0);
                        rf_waddr_d = in_rd;
                        rf_wdata_d = sel_val;
                    end
                end
            end
            ST_WAIT_LD: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                    if (!flush) begin
                        rf_we_d    = ld_we_q && (ld_rd_q != '0);
                        rf_waddr_d = ld_rd_q;
                        rf_wdata_d = ld_fmt;
                    end
                end else if (flush) begin
                    // Response still owed by memory; swallow it in DRAIN
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ld_rd_q    <= '0;
            ld_we_q    <= 1'b0;
            ld_f3_q    <= '0;
            ld_lo_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ld_rd_q    <= ld_rd_d;
            ld_we_q    <= ld_we_d;
            ld_f3_q    <= ld_f3_d;
            ld_lo_q    <= ld_lo_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a behavioural model
// that tracks "pending load" / "draining" rather than FSM states.
module tb_wb_stage;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 4;
    localparam int RA_W    = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              in_sel;
    logic [NUM_SRC*XLEN-1:0] in_src;
    logic [RA_W-1:0]         in_rd;
    logic                    in_we;
    logic [2:0]              in_funct3;
    logic [1:0]              in_addr_lo;
    logic                    mem_rvalid;
    logic [XLEN-1:0]         mem_rdata;
    logic                    flush;
    logic                    rf_we;
    logic [RA_W-1:0]         rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic                    busy;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .MEM_SRC(1), .RA_W(RA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_src     (in_src),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit              m_pend  = 1'b0;
    bit              m_drain = 1'b0;
    logic [RA_W-1:0] m_rd;
    bit              m_we;
    logic [2:0]      m_f3;
    logic [1:0]      m_lo;
    bit              e_we = 1'b0;
    logic [RA_W-1:0] e_waddr = '0;
    logic [XLEN-1:0] e_wdata = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Load formatting from plain shift/mask arithmetic
    function automatic logic [31:0] ref_fmt(input logic [31:0] raw, input logic [2:0] f3,
                                            input logic [1:0] lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (raw >> (8 * lo)) & 32'hFF;
        h = (raw >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return raw;
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid   = 1'b0;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // Advance the model on the current inputs, clock once, compare at negedge
    task automatic tick();
        bit nwe;
        nwe = 1'b0;
        if (!m_pend && !m_drain) begin
            if (in_valid && !flush) begin
                if (in_sel == 2'd1) begin
                    m_pend = 1'b1; m_rd = in_rd; m_we = in_we;
                    m_f3 = in_funct3; m_lo = in_addr_lo;
                end else begin
                    nwe     = in_we && (in_rd != 0);
                    e_waddr = in_rd;
                    e_wdata = in_src[in_sel*32 +: 32];
                end
            end
        end else if (m_pend) begin
            if (mem_rvalid) begin
                m_pend = 1'b0;
                if (!flush) begin
                    nwe     = m_we && (m_rd != 0);
                    e_waddr = m_rd;
                    e_wdata = ref_fmt(mem_rdata, m_f3, m_lo);
                end
            end else if (flush) begin
                m_pend  = 1'b0;
                m_drain = 1'b1;
            end
        end else if (mem_rvalid) begin
            m_drain = 1'b0;
        end
        e_we = nwe;
        @(posedge clk);
        @(negedge clk);
        check("rf_we", rf_we, e_we);
        if (e_we) begin
            check("rf_waddr", rf_waddr, e_waddr);
            check("rf_wdata", rf_wdata, e_wdata);
        end
        check("in_ready", in_ready, !(m_pend || m_drain));
        check("busy", busy, m_pend || m_drain);
    endtask

    task automatic offer(input logic [1:0] sel, input logic [4:0] rd, input bit we,
                         input logic [2:0] f3, input logic [1:0] lo);
        in_valid = 1'b1; in_sel = sel; in_rd = rd; in_we = we;
        in_funct3 = f3; in_addr_lo = lo;
    endtask

    task automatic load_resp(input logic [31:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        in_sel = '0; in_src = '0; in_rd = '0; in_we = 1'b0;
        in_funct3 = '0; in_addr_lo = '0; mem_rdata = '0;
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        #11 rst_n = 1'b1;

        // ALU write
        in_src = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'h1234_5678};
        offer(2'd0, 5'd5, 1'b1, 3'd0, 2'd0);
        tick();
        $display("alu write: rf_we=%0b waddr=%0d wdata=%h", rf_we, rf_waddr, rf_wdata);
        check("alu_wdata", rf_wdata, 32'h1234_5678);
        check("alu_waddr", rf_waddr, 5);
        idle_inputs();
        tick();

        // x0 suppression
        offer(2'd0, 5'd0, 1'b1, 3'd0, 2'd0);
        tick();
        check("x0_rf_we", rf_we, 1'b0);
        $display("x0 write: rf_we=%0b", rf_we);
        idle_inputs();

        // LB sign-extend after 3 idle cycles
        offer(2'd1, 5'd7, 1'b1, 3'b000, 2'd2);
        tick();
        idle_inputs();
        repeat (3) tick();
        load_resp(32'h0080_0000);
        tick();
        check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        check("lb_waddr", rf_waddr, 7);
        $display("LB: waddr=%0d wdata=%h", rf_waddr, rf_wdata);
        idle_inputs();
        tick();

        // LHU and LH on the upper halfword
        offer(2'd1, 5'd9, 1'b1, 3'b101, 2'd2);
        tick();
        idle_inputs();
        tick();
        load_resp(32'h8001_0000);
        tick();
        check("lhu_wdata", rf_wdata, 32'h0000_8001);
        $display("LHU: wdata=%h", rf_wdata);
        idle_inputs();
        offer(2'd1, 5'd10, 1'b1, 3'b001, 2'd3);
        tick();
        idle_inputs();
        load_resp(32'h8001_0000);
        tick();
        check("lh_wdata", rf_wdata, 32'hFFFF_8001);
        $display("LH: wdata=%h", rf_wdata);
        idle_inputs();

        // Flush in IDLE consumes the offer
        offer(2'd2, 5'd3, 1'b1, 3'd0, 2'd0);
        flush = 1'b1;
        tick();
        check("idle_flush_we", rf_we, 1'b0);
        idle_inputs();

        // Flush two cycles before rvalid -> drain
        offer(2'd1, 5'd4, 1'b1, 3'b010, 2'd0);
        tick();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("drain_busy", busy, 1'b1);
        load_resp(32'hCAFE_F00D);
        tick();
        check("drain_we", rf_we, 1'b0);
        check("drain_ready", in_ready, 1'b1);
        $display("flush/drain: rf_we=%0b ready=%0b", rf_we, in_ready);
        idle_inputs();
        offer(2'd3, 5'd12, 1'b1, 3'd0, 2'd0);
        tick();
        check("post_drain_wdata", rf_wdata, 32'hDDDD_0003);
        idle_inputs();

        // Flush coincident with rvalid
        offer(2'd1, 5'd6, 1'b1, 3'b010, 2'd0);
        tick();
        idle_inputs();
        load_resp(32'h1111_2222);
        flush = 1'b1;
        tick();
        check("flush_rv_we", rf_we, 1'b0);
        check("flush_rv_ready", in_ready, 1'b1);
        idle_inputs();

        // Asynchronous reset while waiting for a load
        offer(2'd1, 5'd8, 1'b1, 3'b010, 2'd0);
        tick();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("arst_rf_we", rf_we, 1'b0);
        check("arst_waddr", rf_waddr, 0);
        check("arst_wdata", rf_wdata, 0);
        check("arst_ready", in_ready, 1'b1);
        check("arst_busy", busy, 1'b0);
        $display("async reset: ready=%0b busy=%0b", in_ready, busy);
        m_pend = 1'b0; m_drain = 1'b0; e_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_resp(32'h5555_AAAA);
        tick();
        check("arst_late_rv_we", rf_we, 1'b0);
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 99) < 60);
            in_sel     = 2'($urandom_range(0, 3));
            in_src     = {$urandom, $urandom, $urandom, $urandom};
            in_rd      = 5'($urandom);
            in_we      = ($urandom_range(0, 9) != 0);
            in_funct3  = 3'($urandom);
            in_addr_lo = 2'($urandom);
            mem_rvalid = ($urandom_range(0, 99) < 30);
            mem_rdata  = $urandom;
            flush      = ($urandom_range(0, 99) < 8);
            tick();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
